// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/rvalid handshake,
// buffers them in a small FIFO and hands {instr, pc} to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;
  logic          room;
  logic [31:0]   redir_pc;

  assign redir_pc      = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req      = (state == FETCH) || (state == DROP);
  assign imem_addr     = req_addr;
  assign instr_valid   = (count != '0);
  assign instr         = mem_instr[rd_ptr];
  assign instr_pc      = mem_pc[rd_ptr];
  assign instr_pcplus4 = instr_pc + 32'd4;

  always_comb begin
    pop        = instr_valid & instr_ready;
    push       = (state == FETCH) & imem_rvalid & ~redirect;
    count_next = count + CW'(push) - CW'(pop);
    room       = (count_next < CW'(DEPTH));
  end

  // A redirect flushes the buffer and wins over any push or pop in that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the entries are cleared so instr/instr_pc read 0 out of reset;
      // only acceptable because the buffer is a handful of flops, not a RAM.
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= imem_rdata;
        mem_pc[wr_ptr]    <= req_addr;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

  // NOTE: non-blocking assignments throughout so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redir_pc;
            req_addr <= redir_pc;
            state    <= FETCH;
          end else if (room) begin
            req_addr <= fetch_pc;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (redirect && imem_rvalid) begin
            fetch_pc <= redir_pc;
            req_addr <= redir_pc;
          end else if (redirect) begin
            // The old request must still complete; its data is dropped in DROP.
            fetch_pc <= redir_pc;
            state    <= DROP;
          end else if (imem_rvalid) begin
            fetch_pc <= req_addr + 32'd4;
            if (room) begin
              req_addr <= req_addr + 32'd4;
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect) begin
            fetch_pc <= redir_pc;
          end
          if (imem_rvalid) begin
            req_addr <= redirect ? redir_pc : fetch_pc;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
